elevator_car_model: RTL and testbench
=====================================

Name: elevator_car_model

Overview:
Cycle-based plant model of one elevator car and its door. It consumes the motor and door commands produced by the elevator controller and returns the floor position sensor, so the controller can run closed-loop in simulation and on the FPGA demo board. It models travel time between floors, door open and close time, the shaft end limits and the door/motor interlock. Faults are flagged and latched.

Parameters:
NUM_FLOORS, 4, number of landings; floors are 0..NUM_FLOORS-1.
FLOOR_W, 2, width of the floor index; must satisfy 2^FLOOR_W >= NUM_FLOORS.
TRAVEL_CYCLES, 8, clock cycles to travel one floor; minimum 2.
DOOR_CYCLES, 4, clock cycles for a full door stroke; minimum 1.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
motor_cmd  input  2  00 = stop, 01 = up, 10 = down, 11 = treated as stop
door_cmd  input  1  1 = open request, 0 = close request
position_sensor  output  FLOOR_W  floor register (the lower floor of the current span)
at_floor  output  1  car is level at a landing (offset == 0)
car_moving  output  1  car moved in this cycle
door_open  output  1  door fully open (door_pos == DOOR_CYCLES)
door_closed  output  1  door fully closed (door_pos == 0)
overtravel_fault  output  1  sticky; set when the car is commanded past the top or bottom limit
interlock_fault  output  1  sticky; set when the motor is commanded while the door is not closed

Behaviour:
- Reset (asynchronous): floor=0, offset=0, door_pos=0, both faults=0. Resulting outputs: position_sensor=0, at_floor=1, car_moving=0, door_open=0, door_closed=1.
- Internal state:
  - floor: FLOOR_W bits.
  - offset: 0..TRAVEL_CYCLES-1, cycles above floor.
  - door_pos: 0..DOOR_CYCLES.
- All outputs are registered or decoded directly from registers. A command takes effect on the next clk edge (1-cycle latency).
- Car motion is evaluated each cycle and is enabled only when door_closed=1.
  - Up (01):
    - floor==NUM_FLOORS-1 and offset==0: no move; set overtravel_fault.
    - offset==TRAVEL_CYCLES-1: floor+1, offset=0.
    - Otherwise offset+1.
  - Down (10):
    - floor==0 and offset==0: no move; set overtravel_fault.
    - offset==0: floor-1, offset=TRAVEL_CYCLES-1.
    - Otherwise offset-1.
  - One floor of travel therefore takes exactly TRAVEL_CYCLES cycles in either direction.
  - Reversal mid-span retraces the offset and returns to the same landing.
  - Stop (00/11) mid-span: the car holds position with at_floor=0.
- car_moving=1 in the cycle after any edge at which floor or offset changed.
- Interlock: a motor_cmd of up or down while door_closed=0 causes no motion and sets interlock_fault. Door motion continues normally in that cycle.
- Door state machine. States are derived from door_pos and door_cmd: CLOSED, OPENING, OPEN, CLOSING.
  - door_cmd=1 and door_pos<DOOR_CYCLES: door_pos+1, but only if at_floor=1 and motor_cmd is stop. Otherwise the door holds.
  - door_cmd=0 and door_pos>0: door_pos-1. Closing is always allowed.
  - Reversal mid-stroke (opening to closing or back) continues from the current door_pos with no restart.
  - door_cmd=1 while the car is between floors is ignored: the door stays closed and no fault is raised.
- Simultaneous events:
  - If the door starts opening on the same edge the motor command goes active, the interlock takes priority. The door has not yet left 0, so the motor may move on that edge; the door holds because motor_cmd is not stop.
  - Door and motor are therefore never both in motion from door_pos==0.
- Faults are sticky until reset. They do not inhibit normal operation beyond the interlock and limit rules above.
- Reset asserted mid-travel or mid-stroke returns all state to the reset values immediately.

Test Plan:
- Up one floor: after reset, motor_cmd=01 for 8 cycles, then 00. position_sensor goes 0 to 1 exactly 8 cycles after the first up edge; at_floor=0 for cycles 1-7 and 1 from cycle 8; car_moving=1 for 8 cycles.
- Mid-span reversal: at floor 1, up for 3 cycles, then down for 3 cycles. position_sensor stays 1, at_floor returns to 1 after the 6th cycle, and there are no faults.
- Door cycle: at floor 2, door_cmd=1. door_open=1 after 4 cycles. Then door_cmd=0 after 2 more cycles; door_closed=1 after 4 further cycles.
- Interlock: with the door fully open, apply motor_cmd=01 for 2 cycles. Floor and offset are unchanged and interlock_fault=1 and stays set after the command is removed.
- Limits: at floor 3 (top), motor_cmd=01 sets overtravel_fault=1 with position_sensor=3 unchanged. After reset at floor 0, motor_cmd=10 likewise sets overtravel_fault=1.
- Reset mid-operation: assert reset during down travel at offset 5 with the door closed. Outputs go to the reset values asynchronously (position_sensor=0, at_floor=1, door_closed=1, faults=0).

Source files
------------

// File: rtl/elevator_car_model.sv
// Plant model of one elevator car and its door.
// Returns floor position, door state and latched faults.
module elevator_car_model #(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         motor_cmd,
  input  logic               door_cmd,
  output logic [FLOOR_W-1:0] position_sensor,
  output logic               at_floor,
  output logic               car_moving,
  output logic               door_open,
  output logic               door_closed,
  output logic               overtravel_fault,
  output logic               interlock_fault
);

  localparam int OW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  localparam logic [FLOOR_W-1:0] TOP =
    FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [OW-1:0] OFF_MAX =
    OW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_MAX =
    DW'(DOOR_CYCLES);

  localparam logic [1:0] D_CLOSED  = 2'd0;
  localparam logic [1:0] D_OPENING = 2'd1;
  localparam logic [1:0] D_OPEN    = 2'd2;
  localparam logic [1:0] D_CLOSING = 2'd3;

  logic [FLOOR_W-1:0] floor_q;
  logic [FLOOR_W-1:0] floor_nxt;
  logic [OW-1:0]      offset_q;
  logic [OW-1:0]      offset_nxt;
  logic [DW-1:0]      door_q;
  logic [DW-1:0]      door_nxt;
  logic [1:0]         door_state;
  logic               moving_q;
  logic               moved;
  logic               ot_set;
  logic               il_set;
  logic               cmd_up;
  logic               cmd_dn;
  logic               cmd_stop;

  assign cmd_up   = (motor_cmd == 2'b01);
  assign cmd_dn   = (motor_cmd == 2'b10);
  assign cmd_stop = !cmd_up && !cmd_dn;

  assign position_sensor = floor_q;
  assign at_floor        = (offset_q == '0);
  assign car_moving      = moving_q;
  assign door_open       = (door_q == DOOR_MAX);
  assign door_closed     = (door_q == '0);

  always_comb begin
    floor_nxt  = floor_q;
    offset_nxt = offset_q;
    moved      = 1'b0;
    ot_set     = 1'b0;
    il_set     = 1'b0;
    // Motor is refused while the door is anywhere off its stop.
    if (!cmd_stop && !door_closed) begin
      il_set = 1'b1;
    end else if (cmd_up) begin
      if (floor_q == TOP && at_floor) begin
        ot_set = 1'b1;
      end else if (offset_q == OFF_MAX) begin
        floor_nxt  = floor_q + FLOOR_W'(1);
        offset_nxt = '0;
        moved      = 1'b1;
      end else begin
        offset_nxt = offset_q + OW'(1);
        moved      = 1'b1;
      end
    end else if (cmd_dn) begin
      if (floor_q == '0 && at_floor) begin
        ot_set = 1'b1;
      end else if (at_floor) begin
        floor_nxt  = floor_q - FLOOR_W'(1);
        offset_nxt = OFF_MAX;
        moved      = 1'b1;
      end else begin
        offset_nxt = offset_q - OW'(1);
        moved      = 1'b1;
      end
    end
  end

  always_comb begin
    door_state = D_CLOSED;
    if (door_cmd) begin
      door_state = door_open ? D_OPEN : D_OPENING;
    end else begin
      door_state = door_closed ? D_CLOSED : D_CLOSING;
    end
  end

  always_comb begin
    door_nxt = door_q;
    unique case (door_state)
      D_OPENING: begin
        if (at_floor && cmd_stop) begin
          door_nxt = door_q + DW'(1);
        end
      end
      D_CLOSING: door_nxt = door_q - DW'(1);
      default:   door_nxt = door_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      floor_q          <= '0;
      offset_q         <= '0;
      door_q           <= '0;
      moving_q         <= 1'b0;
      overtravel_fault <= 1'b0;
      interlock_fault  <= 1'b0;
    end else begin
      floor_q  <= floor_nxt;
      offset_q <= offset_nxt;
      door_q   <= door_nxt;
      moving_q <= moved;
      if (ot_set) overtravel_fault <= 1'b1;
      if (il_set) interlock_fault  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_elevator_car_model.sv
// Scoreboard bench for elevator_car_model.
// Model tracks car height in ticks and door stroke as integers.
module tb_elevator_car_model;

  localparam int NF = 4;
  localparam int FW = 2;
  localparam int TC = 8;
  localparam int DC = 4;

  typedef logic [7:0] vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    motor_cmd = 2'b00;
  logic          door_cmd = 1'b0;
  logic [FW-1:0] position_sensor;
  logic          at_floor;
  logic          car_moving;
  logic          door_open;
  logic          door_closed;
  logic          overtravel_fault;
  logic          interlock_fault;

  elevator_car_model #(
    .NUM_FLOORS(NF),
    .FLOOR_W(FW),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .motor_cmd(motor_cmd),
    .door_cmd(door_cmd),
    .position_sensor(position_sensor),
    .at_floor(at_floor),
    .car_moving(car_moving),
    .door_open(door_open),
    .door_closed(door_closed),
    .overtravel_fault(overtravel_fault),
    .interlock_fault(interlock_fault)
  );

  always #5 clk = ~clk;

  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_pos;
  int   m_door;
  bit   m_mov;
  bit   m_ot;
  bit   m_il;

  vec_t act;
  assign act = {position_sensor, at_floor, car_moving,
                door_open, door_closed,
                overtravel_fault, interlock_fault};

  function automatic vec_t model_out();
    logic [FW-1:0] fl;
    fl = FW'(m_pos / TC);
    return {fl, (m_pos % TC) == 0, m_mov,
            m_door == DC, m_door == 0, m_ot, m_il};
  endfunction

  function automatic void model_reset();
    m_pos  = 0;
    m_door = 0;
    m_mov  = 0;
    m_ot   = 0;
    m_il   = 0;
  endfunction

  function automatic void model_step(
    input logic [1:0] mc, input logic dc);
    bit up, dn, stop, closed, lvl;
    up     = (mc == 2'b01);
    dn     = (mc == 2'b10);
    stop   = !up && !dn;
    closed = (m_door == 0);
    lvl    = (m_pos % TC) == 0;
    m_mov  = 0;
    if (!stop && !closed) m_il = 1;
    else if (up) begin
      if (m_pos == (NF - 1) * TC) m_ot = 1;
      else begin m_pos++; m_mov = 1; end
    end else if (dn) begin
      if (m_pos == 0) m_ot = 1;
      else begin m_pos--; m_mov = 1; end
    end
    if (dc && m_door < DC && lvl && stop) m_door++;
    else if (!dc && m_door > 0) m_door--;
  endfunction

  task automatic check(input string name, input vec_t e);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t got {pos,at,mov,open,closed,ot,il}=%b expected %b",
               name, $time, act, e);
    end
  endtask

  task automatic step(input logic [1:0] mc, input logic dc);
    @(negedge clk);
    motor_cmd = mc;
    door_cmd  = dc;
    model_step(mc, dc);
    exp_q.push_back(model_out());
  endtask

  task automatic steps(input int n, input logic [1:0] mc,
                       input logic dc);
    for (int i = 0; i < n; i++) step(mc, dc);
  endtask

  task automatic hit_reset();
    @(posedge clk);
    #2;
    reset     = 1'b1;
    motor_cmd = 2'b00;
    door_cmd  = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    check("async_reset", model_out());
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() > 0) begin
      check("cycle", exp_q.pop_front());
    end
  end

  initial begin
    model_reset();
    #1;
    check("reset_state", model_out());
    repeat (2) @(negedge clk);
    reset = 1'b0;

    steps(8, 2'b01, 1'b0);
    steps(2, 2'b00, 1'b0);
    steps(3, 2'b01, 1'b0);
    steps(3, 2'b10, 1'b0);
    steps(2, 2'b00, 1'b0);
    steps(8, 2'b01, 1'b0);
    steps(6, 2'b00, 1'b1);
    steps(5, 2'b00, 1'b0);
    steps(4, 2'b00, 1'b1);
    steps(2, 2'b01, 1'b1);
    steps(2, 2'b00, 1'b1);
    steps(5, 2'b00, 1'b0);
    steps(8, 2'b01, 1'b0);
    steps(2, 2'b01, 1'b0);
    steps(3, 2'b11, 1'b1);
    hit_reset();
    steps(2, 2'b10, 1'b0);
    hit_reset();
    steps(8, 2'b01, 1'b0);
    steps(3, 2'b10, 1'b0);
    hit_reset();
    steps(3, 2'b00, 1'b1);

    for (int b = 0; b < 250; b++) begin
      logic [1:0] mc;
      logic       dc;
      int         n;
      mc = 2'($urandom_range(0, 3));
      dc = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 10);
      steps(n, mc, dc);
      if ($urandom_range(0, 15) == 0) hit_reset();
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected outputs never checked, required 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
